// File: rtl/cache_port_arbiter_if.sv
// Requester-side and cache-side signal bundle for cache_port_arbiter.
// master = the arbiter itself, slave = core/MMU front-end plus cache.
interface cache_port_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic        err;
   logic [31:0] c_araddr;
   logic        c_arvalid;
   logic        c_arready;
   logic [31:0] c_rdata;
   logic [1:0]  c_rresp;
   logic        c_rvalid;
   logic        c_rready;
   logic [31:0] c_awaddr;
   logic        c_awvalid;
   logic        c_awready;
   logic [31:0] c_wdata;
   logic [3:0]  c_wstrb;
   logic        c_wvalid;
   logic        c_wready;
   logic [1:0]  c_bresp;
   logic        c_bvalid;
   logic        c_bready;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
      input  c_arready, c_rdata, c_rresp, c_rvalid,
      input  c_awready, c_wready, c_bresp, c_bvalid,
      output i_ack, i_rdata, d_ack, d_rdata, err,
      output c_araddr, c_arvalid, c_rready,
      output c_awaddr, c_awvalid, c_wdata, c_wstrb, c_wvalid, c_bready
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wstrb,
      output c_arready, c_rdata, c_rresp, c_rvalid,
      output c_awready, c_wready, c_bresp, c_bvalid,
      input  i_ack, i_rdata, d_ack, d_rdata, err,
      input  c_araddr, c_arvalid, c_rready,
      input  c_awaddr, c_awvalid, c_wdata, c_wstrb, c_wvalid, c_bready
   );
endinterface

// File: rtl/cache_port_arbiter.sv
// Serialises I-fetch reads and D reads/writes onto one AXI-lite cache
// port, one outstanding transaction at a time.
module cache_port_arbiter #(
   parameter bit PRIO_D = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   cache_port_arbiter_if.master bus
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_B    = 3'd4;
   localparam logic [2:0] S_ACK  = 3'd5;

   logic [2:0]  state_q, state_d;
   logic        last_d_q, last_d_d;
   logic        port_d_q, port_d_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic        awvalid_q, awvalid_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        i_ack_q, i_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        err_q, err_d;
   logic [31:0] i_rdata_q, i_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        gnt_d, aw_hs, w_hs;

   // D wins when alone, when prioritised, or when I was served last
   assign gnt_d = bus.d_req & (~bus.i_req | PRIO_D | ~last_d_q);
   assign aw_hs = awvalid_q & bus.c_awready;
   assign w_hs  = wvalid_q & bus.c_wready;

   // Next-state logic: arbitration and AXI channel sequencing
   always_comb begin
      state_d   = state_q;
      last_d_d  = last_d_q;
      port_d_d  = port_d_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      i_rdata_d = i_rdata_q;
      d_rdata_d = d_rdata_q;
      i_ack_d   = 1'b0;
      d_ack_d   = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.i_req | bus.d_req) begin
               port_d_d = gnt_d;
               last_d_d = gnt_d;
               we_d     = gnt_d & bus.d_we;
               addr_d   = gnt_d ? {bus.d_addr[31:2], 2'b00}
                                : {bus.i_addr[31:2], 2'b00};
               wdata_d  = bus.d_wdata;
               wstrb_d  = bus.d_wstrb;
               if (gnt_d & bus.d_we) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = S_AR;
               end
            end
         end
         S_AR: begin
            if (arvalid_q & bus.c_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = S_R;
            end
         end
         S_R: begin
            if (bus.c_rvalid & rready_q) begin
               rready_d = 1'b0;
               err_d    = bus.c_rresp[1];
               if (port_d_q) begin
                  d_rdata_d = bus.c_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = bus.c_rdata;
                  i_ack_d   = 1'b1;
               end
               state_d = S_ACK;
            end
         end
         S_WR: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if ((~awvalid_q | aw_hs) & (~wvalid_q | w_hs)) begin
               bready_d = 1'b1;
               state_d  = S_B;
            end
         end
         S_B: begin
            if (bus.c_bvalid & bready_q) begin
               bready_d = 1'b0;
               d_ack_d  = 1'b1;
               err_d    = bus.c_bresp[1];
               state_d  = S_ACK;
            end
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_d_q  <= 1'b1;
         port_d_q  <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         i_ack_q   <= 1'b0;
         d_ack_q   <= 1'b0;
         err_q     <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         last_d_q  <= last_d_d;
         port_d_q  <= port_d_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         i_ack_q   <= i_ack_d;
         d_ack_q   <= d_ack_d;
         err_q     <= err_d;
         i_rdata_q <= i_rdata_d;
         d_rdata_q <= d_rdata_d;
      end
   end

   assign bus.i_ack     = i_ack_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_ack     = d_ack_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.err       = err_q;
   assign bus.c_araddr  = addr_q;
   assign bus.c_arvalid = arvalid_q;
   assign bus.c_rready  = rready_q;
   assign bus.c_awaddr  = addr_q;
   assign bus.c_awvalid = awvalid_q;
   assign bus.c_wdata   = wdata_q;
   assign bus.c_wstrb   = wstrb_q;
   assign bus.c_wvalid  = wvalid_q;
   assign bus.c_bready  = bready_q;
endmodule

// File: doc/cache_port_arbiter.md
Name:
cache_port_arbiter

Overview:
Shares the cache's single 32-bit AXI-lite-style MMU-side port between an instruction-fetch requester (read-only) and a data requester (read/write). Each requester uses a simple level req/ack interface. The block serialises them into one outstanding AXI transaction at a time. It sits between the CPU core/MMU front-end and the cache.

Parameters:
PRIO_D, 0, 0 = round-robin between I and D; 1 = D has fixed priority over I

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_req  in  1  instruction read request, held until i_ack
i_addr  in  32  instruction byte address
i_ack  out  1  one-cycle completion pulse
i_rdata  out  32  fetched word, valid from i_ack, held until next i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1 = write, 0 = read
d_addr  in  32  data byte address
d_wdata  in  32  write data
d_wstrb  in  4  byte strobes
d_ack  out  1  one-cycle completion pulse
d_rdata  out  32  read word, valid from d_ack, held until next d_ack
err  out  1  pulses with i_ack/d_ack when response bit 1 set
c_araddr  out  32  cache read address
c_arvalid  out  1
c_arready  in  1
c_rdata  in  32
c_rresp  in  2
c_rvalid  in  1
c_rready  out  1
c_awaddr  out  32  cache write address
c_awvalid  out  1
c_awready  in  1
c_wdata  out  32
c_wstrb  out  4
c_wvalid  out  1
c_wready  in  1
c_bresp  in  2
c_bvalid  in  1
c_bready  out  1

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = D, so I wins the first contention. Reset mid-transaction abandons it with no ack.
- Operands must stay stable while req is high. Dropping req before ack is unsupported.
- States:
  - IDLE: arbitration. One req: grant it. Both: PRIO_D=1 grants D. PRIO_D=0 grants the port not in last_grant. Latch port, we, addr[31:2] with low 2 bits forced 00, wdata, wstrb. Update last_grant.
    - Read grant: c_arvalid<=1 -> AR.
    - Write grant: c_awvalid<=1, c_wvalid<=1 -> WR.
  - AR: on c_arvalid&c_arready: c_arvalid<=0, c_rready<=1 -> R.
  - R: on c_rvalid&c_rready: c_rready<=0; latch c_rdata into the granted port's rdata; ack<=1; err<=c_rresp[1] -> ACK.
  - WR: c_awvalid and c_wvalid each drop independently on their own handshake. Once both handshakes are done (same or different cycles): c_bready<=1 -> B.
  - B: on c_bvalid&c_bready: c_bready<=0; ack<=1; err<=c_bresp[1] -> ACK. Write acks leave d_rdata unchanged.
  - ACK: ack and err high exactly one cycle, then cleared -> IDLE.
- Request sampling: requests are sampled only in IDLE. A req held high on the cycle after ack is treated as a new transaction (back-to-back allowed).
- Latency: with a zero-wait cache, req seen at edge 0 gives ack high in cycle 3 for reads and cycle 3 for writes (aw and w accepted together).
- Strays: c_rvalid/c_bvalid arriving while the matching ready is low are ignored.
- Valids stay asserted until their handshake, with no timeout.
- i_ack and d_ack are never high in the same cycle.

Test Plan:
1. i_req, addr 0x100, arready/rvalid immediate, rdata 0xDEADBEEF -> i_ack in cycle 3, i_rdata=0xDEADBEEF, err=0.
2. d_req write, addr 0x203, wdata 0x12345678, wstrb 0x3; awready at +1, wready at +4 -> c_awaddr=0x200; bready only after both handshakes; single d_ack.
3. PRIO_D=0, i_req and d_req held continuously -> grants alternate I,D,I,D; no starvation over 8 transactions.
4. PRIO_D=1, both held -> D served repeatedly; I served only after d_req drops.
5. Read with c_rresp=2'b10 -> err pulses with ack; next transaction has err=0.
6. rst asserted during state R -> all valids/readies/acks 0 next cycle; state IDLE; first post-reset contention grants I.
